mio_bus_responder: RTL
======================

Name: mio_bus_responder

Overview:
- Memory/IO-side responder for the single-cycle CPU's bus request interface (cpu_mio, mem_w, mio_ready).
- Decodes each CPU request to one of three targets: external block RAM, GPIO output register, or free-running counter.
- Inserts a configurable number of wait states, then pulses mio_ready with read data valid.
- Sits between the CPU core and the RAM/peripheral blocks at top level.

Parameters:
- WAIT_CYCLES, 1, wait states between request acceptance and response; legal range 1..15.
- RAM_AW, 10, RAM word-address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_mio  in  1  CPU bus request valid; held until mio_ready.
- mem_w  in  1  1 = write, 0 = read; qualified by cpu_mio.
- addr  in  32  byte address from CPU.
- cpu_data_out  in  32  write data from CPU.
- cpu_data_in  out  32  read data to CPU; valid only while mio_ready = 1.
- mio_ready  out  1  one-cycle completion pulse.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address, addr[RAM_AW+1:2].
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data; 1-cycle synchronous latency.
- gpio_out  out  32  GPIO output register.
- counter_out  out  32  counter value.

Behaviour:
- Address decode, from the latched address:
  - addr[31:28] = 0x0 → RAM.
  - addr[31:28] = 0xE → GPIO.
  - addr[31:28] = 0xF → COUNTER.
  - Any other value → NONE.
- Reset (asynchronous, any state): state = IDLE, wait count = 0, mio_ready = 0, cpu_data_in = 0, ram_we = 0, gpio_out = 0, counter_out = 0, latched addr/data/mem_w = 0. No partial write survives reset.
- IDLE:
  - If cpu_mio = 1, latch addr, mem_w and cpu_data_out, load wait count = WAIT_CYCLES, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Decrement wait count each cycle.
  - ram_addr is driven from the latched address.
  - When the count reaches 1, go to RESP.
  - If cpu_mio drops during WAIT: abort to IDLE, no write performed, no mio_ready.
- RESP (exactly one cycle):
  - mio_ready = 1; next state is IDLE.
  - RAM write: ram_we = 1 this cycle only.
  - GPIO write: gpio_out loads latched data at the end of this cycle.
  - COUNTER write: counter_out loads latched data; the write wins over the increment in the same cycle.
  - NONE write: ignored.
  - Read data on cpu_data_in this cycle:
    - RAM: ram_dout.
    - GPIO: current gpio_out.
    - COUNTER: current counter_out.
    - NONE: 0.
  - cpu_data_in = 0 outside RESP.
- Latency:
  - Request sampled in IDLE at cycle 0; mio_ready = 1 in cycle WAIT_CYCLES+1.
  - Minimum one IDLE cycle between responses. If cpu_mio is still high in that IDLE cycle, it is a new request.
- RAM read timing: ram_addr is stable for ≥1 cycle before RESP (WAIT_CYCLES ≥ 1), so ram_dout is valid in RESP.
- counter_out increments by 1 every cycle outside reset and wraps 0xFFFFFFFF → 0.
- ram_din = latched data whenever state ≠ IDLE, 0 in IDLE.
- Only the latched request is used after acceptance; addr/data changes during WAIT are ignored.

Decomposition:
- Shared package mio_pkg:
  - State encoding IDLE/WAIT/RESP.
  - Target enum RAM/GPIO/COUNTER/NONE.
  - Decode constants for addr[31:28]: 0x0, 0xE, 0xF.
- One sub-module: mio_addr_decode (combinational addr[31:28] → target).
- Counter and GPIO register stay inline.

Test Plan:
- Reset mid-WAIT (rst pulsed while a GPIO write is in WAIT) → all outputs 0, state IDLE, gpio_out remains 0.
- GPIO write then read, WAIT_CYCLES = 1:
  - Write addr 0xE000_0000, data 0x0000_00A5 → mio_ready in cycle 2, gpio_out = 0xA5 after that cycle.
  - Read same address → cpu_data_in = 0xA5 while mio_ready = 1.
- RAM write/read:
  - Write addr 0x0000_0010, data 0xDEADBEEF → ram_we = 1 for one cycle with ram_addr = 4.
  - Read back from the RAM model → cpu_data_in = 0xDEADBEEF at mio_ready.
- Counter:
  - Write 0xFFFF_FFFE to 0xF000_0000 → counter_out = 0xFFFF_FFFE the next cycle, then 0xFFFF_FFFF, then wraps to 0.
  - A read returns the counter value at RESP.
- Abort: cpu_mio dropped in WAIT during a write with WAIT_CYCLES = 3 → no mio_ready, ram_we stays 0, gpio_out unchanged.
- Unmapped address 0x5000_0000:
  - Read → mio_ready pulse, cpu_data_in = 0.
  - Write → no side effects.
  - Back-to-back requests → mio_ready pulses exactly WAIT_CYCLES+2 cycles apart.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types and decode constants for the CPU memory/IO bus responder.
package mio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        TgtRam,
        TgtGpio,
        TgtCounter,
        TgtNone
    } target_e;

    // Region selects taken from addr[31:28]
    localparam logic [3:0] RegionRam     = 4'h0;
    localparam logic [3:0] RegionGpio    = 4'hE;
    localparam logic [3:0] RegionCounter = 4'hF;

endpackage

// File: rtl/mio_addr_decode.sv
// Maps the top address nibble of a bus request to its target.
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [3:0] region_i,
    output logic [1:0] target_o
);

    always_comb begin
        target_o = TgtNone;
        unique case (region_i)
            RegionRam:     target_o = TgtRam;
            RegionGpio:    target_o = TgtGpio;
            RegionCounter: target_o = TgtCounter;
            default:       target_o = TgtNone;
        endcase
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Bus responder: latches a CPU request, waits WAIT_CYCLES, then completes it against
// block RAM, the GPIO output register or the free-running counter.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RAM_AW      = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_mio_i,
    input  logic              mem_w_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       cpu_data_out_i,
    output logic [31:0]       cpu_data_in_o,
    output logic              mio_ready_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_din_o,
    input  logic [31:0]       ram_dout_i,
    output logic [31:0]       gpio_out_o,
    output logic [31:0]       counter_out_o
);

    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    logic        mio_ready_q;
    logic        ram_we_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        mem_w_q;
    logic [31:0] gpio_q;
    logic [31:0] counter_q;
    logic [1:0]  target_raw;
    target_e     target;
    logic        unused_addr_bits;

    mio_addr_decode u_addr_decode (
        .region_i (addr_q[31:28]),
        .target_o (target_raw)
    );

    assign target           = target_e'(target_raw);
    assign unused_addr_bits = ^addr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            mio_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            mem_w_q     <= 1'b0;
        end else begin
            mio_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_mio_i) begin
                        addr_q     <= addr_i;
                        data_q     <= cpu_data_out_i;
                        mem_w_q    <= mem_w_i;
                        wait_cnt_q <= 4'(WAIT_CYCLES);
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    // A dropped request aborts before any side effect is committed
                    if (!cpu_mio_i) begin
                        state_q <= StIdle;
                    end else if (wait_cnt_q <= 4'd1) begin
                        state_q     <= StResp;
                        mio_ready_q <= 1'b1;
                        ram_we_q    <= mem_w_q && (target == TgtRam);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gpio_q    <= 32'd0;
            counter_q <= 32'd0;
        end else begin
            if (state_q == StResp && mem_w_q && target == TgtGpio) begin
                gpio_q <= data_q;
            end
            // A bus write takes priority over the free-running increment
            if (state_q == StResp && mem_w_q && target == TgtCounter) begin
                counter_q <= data_q;
            end else begin
                counter_q <= counter_q + 32'd1;
            end
        end
    end

    always_comb begin
        cpu_data_in_o = 32'd0;
        if (state_q == StResp) begin
            unique case (target)
                TgtRam:     cpu_data_in_o = ram_dout_i;
                TgtGpio:    cpu_data_in_o = gpio_q;
                TgtCounter: cpu_data_in_o = counter_q;
                default:    cpu_data_in_o = 32'd0;
            endcase
        end
    end

    assign mio_ready_o   = mio_ready_q;
    assign ram_we_o      = ram_we_q;
    assign ram_addr_o    = addr_q[RAM_AW+1:2];
    assign ram_din_o     = (state_q != StIdle) ? data_q : 32'd0;
    assign gpio_out_o    = gpio_q;
    assign counter_out_o = counter_q;

endmodule
